// File: rtl/unsat_clause_collector.sv
// Collects clauses that flipped from satisfied to unsatisfied during a flip-evaluation
// batch into a show-ahead FIFO, then waits for the consumer to drain it.
module unsat_clause_collector #(
    parameter int NSAT                  = 3,
    parameter int LITERAL_ADDRESS_WIDTH = 12,
    parameter int FIFO_DEPTH            = 16,
    localparam int CLAUSE_WIDTH         = NSAT * LITERAL_ADDRESS_WIDTH,
    localparam int CNT_WIDTH            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start_i,
    input  logic                    eval_valid_i,
    input  logic [CLAUSE_WIDTH-1:0] eval_clause_i,
    input  logic                    eval_was_sat_i,
    input  logic                    eval_is_sat_i,
    input  logic                    eval_last_i,
    input  logic                    pop_i,
    output logic                    fifo_empty_o,
    output logic [CLAUSE_WIDTH-1:0] fifo_clause_o,
    output logic [CNT_WIDTH-1:0]    fifo_count_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [15:0]             pushed_count_o,
    output logic                    overflow_o
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_WIDTH-1:0]    wrPtr_q, wrPtr_d;
    logic [PTR_WIDTH-1:0]    rdPtr_q, rdPtr_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic [15:0]             pushedCount_q, pushedCount_d;
    logic                    overflow_q, overflow_d;
    logic [CLAUSE_WIDTH-1:0] lastHead_q, lastHead_d;
    logic [CLAUSE_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic fifoEmpty;
    logic fifoFull;
    logic pushReq;
    logic pushOk;
    logic popOk;

    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == CNT_WIDTH'(FIFO_DEPTH));
    assign pushReq   = (state_q == COLLECT) && eval_valid_i && eval_was_sat_i && !eval_is_sat_i;
    assign popOk     = pop_i && !fifoEmpty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pushOk    = pushReq && (!fifoFull || popOk);

    always_comb begin
        state_d       = state_q;
        wrPtr_d       = wrPtr_q;
        rdPtr_d       = rdPtr_q;
        count_d       = count_q;
        pushedCount_d = pushedCount_q;
        overflow_d    = overflow_q;
        lastHead_d    = lastHead_q;
        done_o        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d       = COLLECT;
                    pushedCount_d = '0;
                    overflow_d    = 1'b0;
                end
            end
            COLLECT: begin
                if (eval_valid_i && eval_last_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifoEmpty) begin
                    state_d = IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pushOk) begin
            wrPtr_d = wrPtr_q + PTR_WIDTH'(1);
            if (pushedCount_q != 16'hFFFF) begin
                pushedCount_d = pushedCount_q + 16'd1;
            end
        end else if (pushReq) begin
            overflow_d = 1'b1;
        end

        if (popOk) begin
            rdPtr_d    = rdPtr_q + PTR_WIDTH'(1);
            lastHead_d = mem_q[rdPtr_q];
        end

        case ({pushOk, popOk})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            pushedCount_q <= '0;
            overflow_q    <= 1'b0;
            lastHead_q    <= '0;
        end else begin
            state_q       <= state_d;
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            pushedCount_q <= pushedCount_d;
            overflow_q    <= overflow_d;
            lastHead_q    <= lastHead_d;
        end
    end

    // Storage needs no reset: a slot is only read while the FIFO reports it occupied.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= eval_clause_i;
        end
    end

    assign fifo_empty_o   = fifoEmpty;
    assign fifo_clause_o  = fifoEmpty ? lastHead_q : mem_q[rdPtr_q];
    assign fifo_count_o   = count_q;
    assign busy_o         = (state_q != IDLE);
    assign pushed_count_o = pushedCount_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_unsat_clause_collector.sv
// Directed self-checking bench for unsat_clause_collector with default parameters.
module tb_unsat_clause_collector;

    localparam int CW  = 36;
    localparam int CNW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start_i;
    logic          eval_valid_i;
    logic [CW-1:0] eval_clause_i;
    logic          eval_was_sat_i;
    logic          eval_is_sat_i;
    logic          eval_last_i;
    logic          pop_i;
    logic          fifo_empty_o;
    logic [CW-1:0] fifo_clause_o;
    logic [CNW-1:0] fifo_count_o;
    logic          busy_o;
    logic          done_o;
    logic [15:0]   pushed_count_o;
    logic          overflow_o;

    int vectors = 0;
    int miscompares = 0;

    unsat_clause_collector dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start_i        (start_i),
        .eval_valid_i   (eval_valid_i),
        .eval_clause_i  (eval_clause_i),
        .eval_was_sat_i (eval_was_sat_i),
        .eval_is_sat_i  (eval_is_sat_i),
        .eval_last_i    (eval_last_i),
        .pop_i          (pop_i),
        .fifo_empty_o   (fifo_empty_o),
        .fifo_clause_o  (fifo_clause_o),
        .fifo_count_o   (fifo_count_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .pushed_count_o (pushed_count_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // One evaluation cycle, optionally popping in the same cycle.
    task automatic applyStimulus(input logic [CW-1:0] clause, input logic was, input logic isSat,
                                 input logic last, input logic pop);
        eval_valid_i   = 1'b1;
        eval_clause_i  = clause;
        eval_was_sat_i = was;
        eval_is_sat_i  = isSat;
        eval_last_i    = last;
        pop_i          = pop;
        tick();
        eval_valid_i   = 1'b0;
        eval_last_i    = 1'b0;
        pop_i          = 1'b0;
    endtask

    task automatic popOnce();
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        start_i = 1'b0;
        eval_valid_i = 1'b0;
        eval_clause_i = '0;
        eval_was_sat_i = 1'b0;
        eval_is_sat_i = 1'b0;
        eval_last_i = 1'b0;
        pop_i = 1'b0;
        #3;
        checkOutput("rst_empty", 64'(fifo_empty_o), 64'd1);
        checkOutput("rst_count", 64'(fifo_count_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_done", 64'(done_o), 64'd0);
        checkOutput("rst_pushed", 64'(pushed_count_o), 64'd0);
        checkOutput("rst_ovf", 64'(overflow_o), 64'd0);
        checkOutput("rst_clause", 64'(fifo_clause_o), 64'd0);
        #4 reset_n = 1'b1;
        tick();

        // Basic batch: only (1,0) evaluations push
        pulseStart();
        checkOutput("b_busy", 64'(busy_o), 64'd1);
        applyStimulus(36'hA, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("b_lat_empty", 64'(fifo_empty_o), 64'd0);
        checkOutput("b_lat_head", 64'(fifo_clause_o), 64'hA);
        applyStimulus(36'hB, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(36'hC, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(36'hD, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("b_count", 64'(fifo_count_o), 64'd2);
        checkOutput("b_pushed", 64'(pushed_count_o), 64'd2);
        checkOutput("b_drain_busy", 64'(busy_o), 64'd1);
        checkOutput("b_head0", 64'(fifo_clause_o), 64'hA);
        popOnce();
        checkOutput("b_head1", 64'(fifo_clause_o), 64'hD);
        checkOutput("b_nodone", 64'(done_o), 64'd0);
        popOnce();
        checkOutput("b_done", 64'(done_o), 64'd1);
        checkOutput("b_hold_head", 64'(fifo_clause_o), 64'hD);
        tick();
        checkOutput("b_idle", 64'(busy_o), 64'd0);
        checkOutput("b_done_gone", 64'(done_o), 64'd0);

        // Evaluations in IDLE are ignored
        applyStimulus(36'hE, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("i_count", 64'(fifo_count_o), 64'd0);
        checkOutput("i_busy", 64'(busy_o), 64'd0);
        checkOutput("i_pushed", 64'(pushed_count_o), 64'd2);

        // Overflow: 17 pushes, the last also closes the batch
        pulseStart();
        checkOutput("o_pushed_clr", 64'(pushed_count_o), 64'd0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(36'h100 + 36'(i), 1'b1, 1'b0, (i == 16), 1'b0);
        end
        checkOutput("o_count", 64'(fifo_count_o), 64'd16);
        checkOutput("o_ovf", 64'(overflow_o), 64'd1);
        checkOutput("o_pushed", 64'(pushed_count_o), 64'd16);
        // start_i in DRAIN must not clear anything or change state
        pulseStart();
        checkOutput("d_busy", 64'(busy_o), 64'd1);
        checkOutput("d_ovf", 64'(overflow_o), 64'd1);
        checkOutput("d_count", 64'(fifo_count_o), 64'd16);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("o_pop%0d", i), 64'(fifo_clause_o), 64'h100 + 64'(i));
            popOnce();
        end
        checkOutput("o_done", 64'(done_o), 64'd1);
        tick();
        pulseStart();
        checkOutput("o_ovf_clr", 64'(overflow_o), 64'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++) begin
            applyStimulus(36'h200 + 36'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(36'h2FF, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("f_count", 64'(fifo_count_o), 64'd16);
        checkOutput("f_pushed", 64'(pushed_count_o), 64'd17);
        checkOutput("f_ovf", 64'(overflow_o), 64'd0);
        for (int i = 1; i < 16; i++) begin
            checkOutput($sformatf("f_pop%0d", i), 64'(fifo_clause_o), 64'h200 + 64'(i));
            popOnce();
        end
        checkOutput("f_x_last", 64'(fifo_clause_o), 64'h2FF);
        popOnce();
        checkOutput("f_empty", 64'(fifo_empty_o), 64'd1);
        popOnce();
        checkOutput("f_pop_empty_cnt", 64'(fifo_count_o), 64'd0);
        checkOutput("f_pop_empty_head", 64'(fifo_clause_o), 64'h2FF);
        checkOutput("f_pop_empty_busy", 64'(busy_o), 64'd1);

        // Single entry with push+pop each cycle, wrapping the pointers
        applyStimulus(36'h300, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(36'h301 + 36'(i), 1'b1, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("w_head%0d", i), 64'(fifo_clause_o), 64'h301 + 64'(i));
            checkOutput($sformatf("w_count%0d", i), 64'(fifo_count_o), 64'd1);
        end
        applyStimulus(36'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        popOnce();
        checkOutput("w_done", 64'(done_o), 64'd1);
        tick();

        // Asynchronous reset in the middle of a batch
        pulseStart();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(36'h400 + 36'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("r_pre_count", 64'(fifo_count_o), 64'd5);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("r_empty", 64'(fifo_empty_o), 64'd1);
        checkOutput("r_busy", 64'(busy_o), 64'd0);
        checkOutput("r_count", 64'(fifo_count_o), 64'd0);
        checkOutput("r_pushed", 64'(pushed_count_o), 64'd0);
        #1 reset_n = 1'b1;
        tick();
        applyStimulus(36'h4FF, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("r_ignore", 64'(fifo_count_o), 64'd0);
        pulseStart();
        applyStimulus(36'h500, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("r_new_count", 64'(fifo_count_o), 64'd1);
        checkOutput("r_new_head", 64'(fifo_clause_o), 64'h500);
        checkOutput("r_new_pushed", 64'(pushed_count_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/unsat_clause_collector.md
UNSAT_CLAUSE_COLLECTOR -- requirements
Module: unsat_clause_collector

Interface
REQ-001 SHALL have parameter NSAT, default 3, literals per clause.
REQ-002 SHALL have parameter LITERAL_ADDRESS_WIDTH, default 12, bits per literal; CLAUSE_WIDTH = NSAT*LITERAL_ADDRESS_WIDTH.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two, >=2; CNT_WIDTH = clog2(FIFO_DEPTH)+1.
REQ-004 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have start_i  input  1  one-cycle pulse opening a flip-evaluation batch.
REQ-007 SHALL have eval_valid_i  input  1  clause evaluation present this cycle.
REQ-008 SHALL have eval_clause_i  input  CLAUSE_WIDTH  clause literals being evaluated.
REQ-009 SHALL have eval_was_sat_i  input  1  clause satisfied before the flip.
REQ-010 SHALL have eval_is_sat_i  input  1  clause satisfied after the flip.
REQ-011 SHALL have eval_last_i  input  1  qualifies eval_valid_i; final evaluation of batch.
REQ-012 SHALL have pop_i  input  1  consumer (unsat clause selector) takes head entry.
REQ-013 SHALL have fifo_empty_o  output  1  no entry available.
REQ-014 SHALL have fifo_clause_o  output  CLAUSE_WIDTH  head entry (show-ahead).
REQ-015 SHALL have fifo_count_o  output  CNT_WIDTH  entries held.
REQ-016 SHALL have busy_o  output  1  state != IDLE.
REQ-017 SHALL have done_o  output  1  one-cycle pulse, batch collected and drained.
REQ-018 SHALL have pushed_count_o  output  16  clauses pushed this batch, saturating at 16'hFFFF.
REQ-019 SHALL have overflow_o  output  1  sticky: a push was dropped this batch.

Function
REQ-020 SHALL implement states IDLE, COLLECT, DRAIN; start_i in IDLE -> COLLECT; eval_valid_i&eval_last_i in COLLECT -> DRAIN; DRAIN with fifo_count_o==0 -> IDLE, asserting done_o for that one transition cycle.
REQ-021 SHALL ignore start_i outside IDLE and eval_valid_i outside COLLECT.
REQ-022 SHALL, on start_i accepted, clear pushed_count_o and overflow_o on the next edge; FIFO contents are retained.
REQ-023 SHALL push eval_clause_i iff state==COLLECT, eval_valid_i=1, eval_was_sat_i=1, eval_is_sat_i=0 (sat->unsat transition); all other combinations push nothing.
REQ-024 SHALL accept at most one push and one pop per cycle; a push with eval_last_i=1 is processed before entering DRAIN.
REQ-025 SHALL make a pushed clause visible at fifo_clause_o and deassert fifo_empty_o on the cycle after the push edge (1-cycle latency), when FIFO was empty.
REQ-026 SHALL advance the head on pop_i when fifo_empty_o=0; pop_i while empty SHALL be ignored with no state change.
REQ-027 SHALL, when full and push requested without pop, drop the clause, set overflow_o, leave contents, count and pushed_count_o unchanged.
REQ-028 SHALL, when full with simultaneous push and pop, perform both; fifo_count_o stays FIFO_DEPTH.
REQ-029 SHALL, with simultaneous push and pop on a single-entry FIFO, present the new clause next cycle, count stays 1.
REQ-030 SHALL wrap read/write pointers modulo FIFO_DEPTH; fifo_count_o = pushes - pops, range 0..FIFO_DEPTH.
REQ-031 SHALL increment pushed_count_o on each accepted push only.
REQ-032 SHALL keep fifo_clause_o equal to the last head value when empty (no X propagation).

Reset
REQ-033 SHALL, on reset_n=0, immediately force state IDLE, pointers and fifo_count_o 0, fifo_empty_o 1, busy_o 0, done_o 0, pushed_count_o 0, overflow_o 0, fifo_clause_o 0.
REQ-034 SHALL, on reset mid-batch, discard all entries; first post-reset start_i behaves as from power-up.

Verification
REQ-035 Batch: start, 4 evals (was,is)=(1,0),(1,1),(0,0),(1,0 last) -> 2 pushes, pushed_count_o=2, clauses in order, done_o after both popped.
REQ-036 Overflow: DEPTH=16, no pops, 17 sat->unsat evals -> count 16, 17th dropped, overflow_o=1, pushed_count_o=16; next start_i clears overflow_o.
REQ-037 Full push+pop: full FIFO, push X with pop -> count 16, X emerges as 16th pop; pop while empty -> no change.
REQ-038 Wrap: 40 push/pop pairs interleaved -> FIFO-order data correct across pointer wrap, count never exceeds 16.
REQ-039 Reset: assert reset_n low mid-COLLECT with 5 entries -> same-cycle fifo_empty_o=1, busy_o=0, count 0; eval_valid_i ignored until start_i.
REQ-040 Ignore: start_i during DRAIN and eval_valid_i in IDLE -> no push, no state change.
